// File: rtl/axis_video_pkg.sv
// axis_video_pkg: shared types and helpers for the AXIS video pattern checker
package axis_video_pkg;
  typedef enum logic {UNLOCK = 1'b0, LOCK = 1'b1} state_t;
  localparam int ERR_CNT_W = 16;
  function automatic int words_per_line(input int h);
    return h / 4;
  endfunction
  function automatic logic [31:0] exp_pixel(input logic [15:0] word, input logic [3:0] frame, input logic [11:0] line);
    return {16'h0, word} + {frame, line, 16'h0};
  endfunction
endpackage

// File: rtl/axis_lfsr_throttle.sv
// axis_lfsr_throttle: pseudo-random ready generator from a 16-bit Galois LFSR (taps 16,14,13,11)
// Ports: clk, rst (sync, active-high), en_out (registered LFSR bit 0, low in reset)
module axis_lfsr_throttle #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  output logic en_out
);
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr   <= SEED;
      en_out <= 1'b0;
    end else begin
      lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
      en_out <= lfsr[0];
    end
  end
endmodule

// File: rtl/saxis_video_pattern_checker.sv
// saxis_video_pattern_checker: AXI4-Stream sink checking the video test pattern, TUSER/TLAST framing and error stats
// Ports: S_AXIS_* slave stream (S_AXIS_ACLK clock, S_AXIS_ARESET sync active-high reset),
//   err_clear pulse; status locked, frame_done, frames_ok, err_cnt, err_flag, err_expected, err_actual.
// Macro SAXIS_CHECKER_BACKPRESSURE_EN: drive TREADY from an LFSR instead of constant 1.
module saxis_video_pattern_checker
  import axis_video_pkg::*;
#(
  parameter int          C_S_AXIS_TDATA_WIDTH = 32,
  parameter int          PIXELS_HORIZONTAL    = 1280,
  parameter int          PIXELS_VERTICAL      = 1024,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESET,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [3:0]                      S_AXIS_TSTRB,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TUSER,
  input  logic                            err_clear,
  output logic                            locked,
  output logic                            frame_done,
  output logic [15:0]                     frames_ok,
  output logic [ERR_CNT_W-1:0]            err_cnt,
  output logic                            err_flag,
  output logic [31:0]                     err_expected,
  output logic [31:0]                     err_actual
);
  localparam int          WORDS = words_per_line(PIXELS_HORIZONTAL);
  localparam logic [15:0] WLAST = 16'(WORDS - 1);
  localparam logic [11:0] LLAST = 12'(PIXELS_VERTICAL - 1);
  if (C_S_AXIS_TDATA_WIDTH != 32 || WORDS < 2 || PIXELS_VERTICAL < 1 || PIXELS_VERTICAL > 4096 || LFSR_SEED == 16'h0) begin : g_bad_cfg
    $error("saxis_video_pattern_checker: unsupported configuration");
  end
  state_t      state, state_nx;
  logic [15:0] word;
  logic [11:0] line;
  logic [3:0]  frame;
  logic        beat, sync, eol, eof, err, good;
  logic [31:0] exp_data;
  always_comb begin
    beat     = S_AXIS_TVALID & S_AXIS_TREADY;
    sync     = S_AXIS_TUSER && S_AXIS_TDATA[27:0] == 28'h0;
    eol      = word == WLAST;
    eof      = eol && line == LLAST;
    // While unlocked the only checkable beat is the sync beat, whose expected value is itself.
    exp_data = state == LOCK ? exp_pixel(word, frame, line) : {S_AXIS_TDATA[31:28], 28'h0};
    err      = beat && (state == LOCK ?
               (S_AXIS_TDATA != exp_data || S_AXIS_TUSER != (word == 16'd0 && line == 12'd0) ||
                S_AXIS_TLAST != eol || S_AXIS_TSTRB != 4'hF) :
               (sync && S_AXIS_TLAST));
    good     = beat && !err && (state == LOCK || sync);
  end
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) state <= UNLOCK;
    else state <= state_nx;
  end
  always_comb state_nx = err ? UNLOCK : good ? LOCK : state;
  always_comb locked = state == LOCK;
  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      word         <= '0;
      line         <= '0;
      frame        <= '0;
      frames_ok    <= '0;
      frame_done   <= 1'b0;
      err_cnt      <= '0;
      err_flag     <= 1'b0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      frame_done <= good && state == LOCK && eof;
      if (good && state == UNLOCK) begin
        frame <= S_AXIS_TDATA[31:28];
        word  <= 16'd1;
        line  <= '0;
      end else if (good) begin
        word  <= eol ? 16'd0 : word + 16'd1;
        line  <= eof ? 12'd0 : eol ? line + 12'd1 : line;
        frame <= eof ? frame + 4'd1 : frame;
        frames_ok <= eof ? frames_ok + 16'd1 : frames_ok;
      end
      // An error beat overrides a simultaneous clear, restarting the stats from this error.
      if (err) begin
        err_cnt  <= err_clear ? ERR_CNT_W'(1) : (&err_cnt ? err_cnt : err_cnt + ERR_CNT_W'(1));
        err_flag <= 1'b1;
        if (err_clear || !err_flag) begin
          err_expected <= exp_data;
          err_actual   <= S_AXIS_TDATA;
        end
      end else if (err_clear) begin
        err_cnt      <= '0;
        err_flag     <= 1'b0;
        err_expected <= '0;
        err_actual   <= '0;
      end
    end
  end
`ifdef SAXIS_CHECKER_BACKPRESSURE_EN
  axis_lfsr_throttle #(.SEED(LFSR_SEED)) u_throttle (
    .clk(S_AXIS_ACLK),
    .rst(S_AXIS_ARESET),
    .en_out(S_AXIS_TREADY)
  );
`else
  always_ff @(posedge S_AXIS_ACLK) S_AXIS_TREADY <= !S_AXIS_ARESET;
`endif
endmodule
